xcorr_scan_ctrl: RTL and testbench

// Sequencer feeding the serial cross-correlation unit in the pitch-shift path.
// On i_start it reads the predict frame from one memory and each candidate

---
 rtl/xcorr_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_xcorr_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_scan_ctrl.sv
// Scan sequencer for the serial cross-correlator: streams predict/candidate sample
// pairs with aligned indices, then captures the correlator's best index.
module xcorr_scan_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int NUM_CAND  = 1024,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 1,
    parameter int CORR_LAT  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_poss_addr,
    output logic [9:0]        o_pred_addr,
    input  logic [15:0]       i_poss_data,
    input  logic [15:0]       i_pred_data,
    output logic              o_corr_clr,
    output logic              o_valid,
    output logic [15:0]       o_poss_data,
    output logic [15:0]       o_pred_data,
    output logic [10:0]       o_counter,
    output logic [9:0]        o_data_counter,
    input  logic [10:0]       i_index,
    output logic              o_busy,
    output logic              o_done,
    output logic [10:0]       o_best_offset
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [10:0] K_LAST = 11'(NUM_CAND - 1);
    localparam logic [9:0]  N_LAST = 10'(FRAME_LEN - 1);
    localparam int          DW = $clog2(RD_LAT + CORR_LAT + 3);
    localparam logic [DW-1:0] DRAIN_LD = DW'(RD_LAT + 1 + CORR_LAT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [10:0]       k;
    logic [9:0]        n;
    logic [DW-1:0]     drain_cnt;
    logic              issue_last;

    logic [RD_LAT-1:0] dly_v;
    logic [10:0]       dly_k [RD_LAT];
    logic [9:0]        dly_n [RD_LAT];

    assign issue_last = (k == K_LAST) && (n == N_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_rd_en    = 1'b0;
        o_corr_clr = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nxt = S_CLR;
            end
            S_CLR: begin
                o_corr_clr = 1'b1;
                state_nxt  = S_ISSUE;
            end
            S_ISSUE: begin
                o_rd_en = 1'b1;
                if (issue_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                o_busy    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Drain is loaded with the pipeline depth and still spends its terminal-count
    // cycle in DRAIN, giving the correlator index one extra cycle to settle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base      <= '0;
            k         <= '0;
            n         <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == S_IDLE && i_start) base <= i_base_addr;
            if (state == S_ISSUE) begin
                if (n == N_LAST) begin
                    n <= '0;
                    k <= issue_last ? 11'd0 : k + 11'd1;
                end else begin
                    n <= n + 10'd1;
                end
            end
            if (state == S_ISSUE && issue_last)         drain_cnt <= DRAIN_LD;
            else if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        end
    end

    assign o_poss_addr = o_rd_en ? (base + ADDR_W'(k) + ADDR_W'(n)) : '0;
    assign o_pred_addr = o_rd_en ? n : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dly_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dly_k[i] <= '0;
                dly_n[i] <= '0;
            end
        end else begin
            dly_v[0] <= o_rd_en;
            dly_k[0] <= k;
            dly_n[0] <= n;
            for (int i = 1; i < RD_LAT; i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_k[i] <= dly_k[i-1];
                dly_n[i] <= dly_n[i-1];
            end
        end
    end

    // Zeroed data while invalid keeps the correlator sum untouched; indices hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid        <= 1'b0;
            o_poss_data    <= '0;
            o_pred_data    <= '0;
            o_counter      <= '0;
            o_data_counter <= '0;
            o_best_offset  <= '0;
        end else begin
            o_valid <= dly_v[RD_LAT-1];
            if (dly_v[RD_LAT-1]) begin
                o_poss_data    <= i_poss_data;
                o_pred_data    <= i_pred_data;
                o_counter      <= dly_k[RD_LAT-1];
                o_data_counter <= dly_n[RD_LAT-1];
            end else begin
                o_poss_data <= '0;
                o_pred_data <= '0;
            end
            if (state == S_DONE) o_best_offset <= i_index;
        end
    end

endmodule

// File: tb/tb_xcorr_scan_ctrl.sv
// Bench for xcorr_scan_ctrl: memories and correlator around the DUT, a cycle-level
// reference of the scan timeline, and directed plus randomized scans.
module tb_xcorr_scan_ctrl;
    localparam int FL = 4;
    localparam int NC = 8;
    localparam int AW = 6;
    localparam int RL = 1;
    localparam int CL = 1;
    localparam int T_RD0  = 2;
    localparam int T_V0   = T_RD0 + RL + 1;
    localparam int NPAIR  = NC * FL;
    localparam int T_DONE = T_V0 + NPAIR + CL + 1;

    logic clk = 1'b0;
    logic rst, start;
    logic [AW-1:0] base_in;
    logic rd_en, corr_clr, valid, busy, done;
    logic [AW-1:0] poss_addr;
    logic [9:0] pred_addr, dcnt;
    logic [15:0] poss_q, pred_q, poss_out, pred_out;
    logic [10:0] cnt, best_idx, best_off;

    logic signed [15:0] poss_mem [64];
    logic signed [15:0] pred_mem [FL];

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    xcorr_scan_ctrl #(.FRAME_LEN(FL), .NUM_CAND(NC), .ADDR_W(AW), .RD_LAT(RL), .CORR_LAT(CL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_in),
        .o_rd_en(rd_en), .o_poss_addr(poss_addr), .o_pred_addr(pred_addr),
        .i_poss_data(poss_q), .i_pred_data(pred_q), .o_corr_clr(corr_clr),
        .o_valid(valid), .o_poss_data(poss_out), .o_pred_data(pred_out),
        .o_counter(cnt), .o_data_counter(dcnt), .i_index(best_idx),
        .o_busy(busy), .o_done(done), .o_best_offset(best_off)
    );

    // Memories with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            poss_q <= poss_mem[poss_addr];
            pred_q <= pred_mem[pred_addr[1:0]];
        end
    end

    // Behavioural correlator: per-candidate dot product, first maximum wins.
    longint acc, best_sum, csum;
    always @(posedge clk) begin
        if (rst || corr_clr) begin
            acc      <= 0;
            best_sum <= -(longint'(1) <<< 62);
            best_idx <= '0;
        end else if (valid) begin
            csum = acc + longint'($signed(poss_out)) * longint'($signed(pred_out));
            if (dcnt == 10'(FL - 1)) begin
                acc <= 0;
                if (csum > best_sum) begin
                    best_sum <= csum;
                    best_idx <= cnt;
                end
            end else begin
                acc <= csum;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] model_best(input int b);
        longint bs, s;
        int bi;
        bs = -(longint'(1) <<< 62);
        bi = 0;
        for (int kk = 0; kk < NC; kk++) begin
            s = 0;
            for (int nn = 0; nn < FL; nn++)
                s += longint'(poss_mem[(b + kk + nn) % 64]) * longint'(pred_mem[nn]);
            if (s > bs) begin
                bs = s;
                bi = kk;
            end
        end
        return 11'(bi);
    endfunction

    // Reference timeline: mt is the cycle number since the accepted start, -1 when idle.
    int mt = -1;
    int mbase = 0;
    logic [10:0] m_best = '0, m_best_next = '0, m_k = '0;
    logic [9:0] m_n = '0;
    logic e_rd, e_valid;
    logic [AW-1:0] e_pa;
    logic [9:0] e_qa;
    logic [15:0] e_pd, e_qd;

    always @(negedge clk) begin
        int j;
        j = mt - T_RD0;
        e_rd = (mt >= T_RD0) && (mt < T_RD0 + NPAIR);
        e_pa = e_rd ? AW'((mbase + j / FL + j % FL) % 64) : '0;
        e_qa = e_rd ? 10'(j % FL) : '0;
        e_valid = (mt >= T_V0) && (mt < T_V0 + NPAIR);
        e_pd = '0;
        e_qd = '0;
        if (e_valid) begin
            j = mt - T_V0;
            m_k = 11'(j / FL);
            m_n = 10'(j % FL);
            e_pd = poss_mem[(mbase + j / FL + j % FL) % 64];
            e_qd = pred_mem[j % FL];
        end
        chk("rd_en", rd_en, e_rd);
        chk("poss_addr", poss_addr, e_pa);
        chk("pred_addr", pred_addr, e_qa);
        chk("corr_clr", corr_clr, mt == 1);
        chk("valid", valid, e_valid);
        chk("poss_data", poss_out, e_pd);
        chk("pred_data", pred_out, e_qd);
        chk("counter", cnt, m_k);
        chk("data_counter", dcnt, m_n);
        chk("busy", busy, mt >= 1);
        chk("done", done, mt == T_DONE);
        chk("best_offset", best_off, m_best);
        if (done === 1'b1) done_count++;
        if (rst) begin
            mt = -1;
            m_best = '0;
            m_k = '0;
            m_n = '0;
        end else if (mt < 0) begin
            if (start) begin
                mt = 1;
                mbase = int'(base_in);
                m_best_next = model_best(int'(base_in));
            end
        end else if (mt == T_DONE) begin
            m_best = m_best_next;
            mt = -1;
        end else begin
            mt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a scan and records key event cycles; returns at the negedge after DONE.
    task automatic run_scan(input logic [AW-1:0] b, input bit jitter);
        int c, clr_c, rd_f, rd_l, v_f, v_l, dn_c;
        clr_c = -1; rd_f = -1; rd_l = -1; v_f = -1; v_l = -1; dn_c = -1;
        step();
        base_in = b;
        start = 1'b1;
        c = 0;
        while (dn_c < 0 && c < 80) begin
            step();
            c++;
            start = jitter && (c <= T_DONE) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (corr_clr && clr_c < 0) clr_c = c;
            if (rd_en) begin
                if (rd_f < 0) rd_f = c;
                rd_l = c;
            end
            if (valid) begin
                if (v_f < 0) v_f = c;
                v_l = c;
            end
            if (done) dn_c = c;
        end
        start = 1'b0;
        chk("clr_cycle", clr_c, 1);
        chk("rd_first_cycle", rd_f, 2);
        chk("rd_last_cycle", rd_l, 33);
        chk("valid_first_cycle", v_f, 4);
        chk("valid_last_cycle", v_l, 35);
        chk("done_cycle", dn_c, 38);
        step();
        @(negedge clk);
    endtask

    initial begin
        int act, d0;
        rst = 1'b1;
        start = 1'b0;
        base_in = '0;
        for (int i = 0; i < 64; i++) poss_mem[i] = '0;
        for (int i = 0; i < FL; i++) pred_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_best", best_off, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);

        // Sequencing with arbitrary contents from base 0
        for (int i = 0; i < 64; i++) poss_mem[i] = 16'($urandom);
        for (int i = 0; i < FL; i++) pred_mem[i] = 16'($urandom);
        run_scan(6'd0, 1'b0);

        // Peak detect
        for (int i = 0; i < 64; i++) poss_mem[i] = '0;
        pred_mem[0] = 16'sd100; pred_mem[1] = -16'sd200;
        pred_mem[2] = 16'sd300; pred_mem[3] = -16'sd400;
        for (int i = 0; i < FL; i++) poss_mem[10 + i] = pred_mem[i];
        run_scan(6'd5, 1'b0);
        chk("peak_best", best_off, 5);
        chk("peak_model_pin", m_best, 5);

        // Address wrap
        for (int i = 0; i < 64; i++) poss_mem[i] = '0;
        for (int i = 0; i < FL; i++) poss_mem[1 + i] = pred_mem[i];
        run_scan(6'd62, 1'b0);
        chk("wrap_best", best_off, 3);
        chk("wrap_model_pin", m_best, 3);

        // Start while busy, at DONE, and one cycle after DONE
        d0 = done_count;
        step();
        base_in = 6'd20;
        start = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            step();
            start = (c == 10) || (c == 38);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("restart_busy", busy, 1);
        repeat (45) step();
        chk("back_to_back_dones", done_count - d0, 2);

        // Reset mid-scan
        step();
        base_in = 6'd9;
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        d0 = done_count;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_counter", cnt, 0);
        chk("abort_best", best_off, 0);
        repeat (50) step();
        chk("abort_no_done", done_count - d0, 0);
        run_scan(6'd9, 1'b0);

        // Idle hold
        act = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            @(negedge clk);
            if (valid || rd_en || poss_out != 0 || pred_out != 0) act++;
        end
        chk("idle_activity", act, 0);

        // Randomized scans with spurious starts while busy
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) poss_mem[i] = 16'($urandom);
            for (int i = 0; i < FL; i++) pred_mem[i] = 16'($urandom);
            run_scan(6'($urandom), 1'b1);
            chk("rand_best", best_off, m_best);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
